conv2d_window_sched: RTL and testbench
======================================

CONV2D_WINDOW_SCHED -- requirements
Module: conv2d_window_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (4..64).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (4..64).
REQ-003 SHALL have parameter DATA_W, default 8, signed pixel width.
REQ-004 SHALL have parameter ACC_W, default 16, signed result width.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 SHALL have port S_AXI_ACLK  in  1  clock.
REQ-007 SHALL have port S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-008 SHALL have port start  in  1  single-cycle run request.
REQ-009 SHALL have port abort  in  1  synchronous run cancel.
REQ-010 SHALL have port busy  out  1  run in progress.
REQ-011 SHALL have port done  out  1  single-cycle run-complete pulse.
REQ-012 SHALL have port pix_rd_en  out  1  pixel memory read strobe.
REQ-013 SHALL have port pix_addr  out  12  row-major pixel address (row*IMG_W+col).
REQ-014 SHALL have port pix_rdata  in  DATA_W  read data, valid 1 cycle after pix_rd_en.
REQ-015 SHALL have port core_start  out  1  single-cycle conv core start.
REQ-016 SHALL have port core_pix  out  9*DATA_W  window, element k at bits [k*DATA_W +: DATA_W], k=3*r+c.
REQ-017 SHALL have port core_done  in  1  conv core completion pulse.
REQ-018 SHALL have port core_result  in  ACC_W  conv core result, valid with core_done.
REQ-019 SHALL have port out_valid  out  1  result available.
REQ-020 SHALL have port out_ready  in  1  consumer accepts result.
REQ-021 SHALL have port out_data  out  ACC_W  result.
REQ-022 SHALL have port out_addr  out  12  output index, row-major over (IMG_H-2)x(IMG_W-2).

Function
REQ-023 SHALL implement FSM states IDLE, FETCH, COMPUTE, WAIT, WRITE, ADVANCE, DONE.
REQ-024 IDLE: start=1 -> FETCH with window origin (row,col)=(0,0), out index 0; busy=1 in every state except IDLE.
REQ-025 FETCH: SHALL issue 9 reads on 9 consecutive cycles, k=0..8, address (row+k/3)*IMG_W+col+k%3; SHALL capture pix_rdata into window slot k one cycle after each read; SHALL exit to COMPUTE on the cycle after the 9th capture (10 cycles after entry).
REQ-026 COMPUTE: SHALL assert core_start for exactly one cycle with core_pix stable, then -> WAIT; core_pix SHALL remain stable until core_done.
REQ-027 WAIT: core_done=1 -> latch core_result, -> WRITE.
REQ-028 WRITE: out_valid=1 with out_data/out_addr stable until the cycle out_valid&&out_ready; then -> ADVANCE.
REQ-029 ADVANCE: col<IMG_W-3 -> col+1; else col=0, row+1; if the finished window was (IMG_H-3,IMG_W-3) -> DONE, else -> FETCH; out index +1.
REQ-030 DONE: done=1 for one cycle, -> IDLE.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, deassert out_valid, and not pulse done; abort takes priority over all other transitions.
REQ-033 core_done outside WAIT SHALL be ignored.
REQ-034 Total results per run SHALL be (IMG_W-2)*(IMG_H-2); out_addr SHALL never exceed that minus 1.

Reset
REQ-035 On S_AXI_ARESETN=0: state IDLE, busy/done/pix_rd_en/core_start/out_valid 0, pix_addr/core_pix/out_data/out_addr 0, row/col/index 0.
REQ-036 Reset mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-037 Macro CONV_SCHED_RELU_EN defined: out_data SHALL be 0 when latched core_result is negative, else core_result.
REQ-038 Macro CONV_SCHED_RELU_EN undefined: out_data SHALL equal core_result unmodified (signed).

Verification
REQ-039 All-ones 8x8 image, core model sums window, out_ready=1 -> 36 results, each 9, out_addr 0..35, one done pulse.
REQ-040 Pixel value = row*8+col, summing core -> out_addr 0 data 81, out_addr 35 data 486; pix_addr sequence for window 0 is 0,1,2,8,9,10,16,17,18.
REQ-041 out_ready held 0 for 20 cycles at result 5 -> out_valid, out_data, out_addr stable for those cycles; no new pix_rd_en meanwhile.
REQ-042 abort asserted during WAIT of window 10 -> IDLE next cycle, busy=0, no done; subsequent start restarts at out_addr 0.
REQ-043 Core returns -7: with CONV_SCHED_RELU_EN out_data=0; without it out_data=-7 (0xFFF9).
REQ-044 start pulsed mid-run and core_done pulsed during FETCH -> no restart, no extra result, result count still 36.

Source files
------------

// File: rtl/conv2d_window_sched.sv
// conv2d_window_sched: walks 3x3 windows over an IMG_H x IMG_W image, fetches each window,
// hands it to a conv core and streams results. Optional macro CONV_SCHED_RELU_EN clamps negatives.
module conv2d_window_sched #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                pix_rd_en,
    output logic [11:0]         pix_addr,
    input  logic [DATA_W-1:0]   pix_rdata,
    output logic                core_start,
    output logic [9*DATA_W-1:0] core_pix,
    input  logic                core_done,
    input  logic [ACC_W-1:0]    core_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic [11:0]         out_addr
);

    localparam logic [6:0]  ColLast = 7'(IMG_W - 3);
    localparam logic [6:0]  RowLast = 7'(IMG_H - 3);
    localparam logic [11:0] ImgW12  = 12'(IMG_W);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCompute,
        StWait,
        StWrite,
        StAdvance,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [6:0]        row_q, row_d;
    logic [6:0]        col_q, col_d;
    logic [11:0]       idx_q, idx_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0] win_q [9];
    logic              win_we;
    logic [3:0]        win_sel;
    logic [1:0]        kr, kc;

    // Window element offset for the read issued in fetch cycle fcnt_q.
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (fcnt_q)
            4'd1: kc = 2'd1;
            4'd2: kc = 2'd2;
            4'd3: kr = 2'd1;
            4'd4: begin kr = 2'd1; kc = 2'd1; end
            4'd5: begin kr = 2'd1; kc = 2'd2; end
            4'd6: kr = 2'd2;
            4'd7: begin kr = 2'd2; kc = 2'd1; end
            4'd8: begin kr = 2'd2; kc = 2'd2; end
            default: begin kr = 2'd0; kc = 2'd0; end
        endcase
    end

    always_comb begin
        pix_rd_en = (state_q == StFetch) && (fcnt_q < 4'd9);
        pix_addr  = '0;
        if (pix_rd_en) begin
            pix_addr = (12'(row_q) + 12'(kr)) * ImgW12 + 12'(col_q) + 12'(kc);
        end
        // Read data returns one cycle late, so slot k lands in fetch cycle k+1.
        win_we  = (state_q == StFetch) && (fcnt_q != 4'd0);
        win_sel = fcnt_q - 4'd1;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = '0;
        row_d   = row_q;
        col_d   = col_q;
        idx_d   = idx_q;
        res_d   = res_q;
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StFetch;
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                    end
                end
                StFetch: begin
                    if (fcnt_q == 4'd9) begin
                        state_d = StCompute;
                    end else begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
                StCompute: state_d = StWait;
                StWait: begin
                    if (core_done) begin
`ifdef CONV_SCHED_RELU_EN
                        res_d = core_result[ACC_W-1] ? '0 : core_result;
`else
                        res_d = core_result;
`endif
                        state_d = StWrite;
                    end
                end
                StWrite: begin
                    if (out_ready) begin
                        state_d = StAdvance;
                    end
                end
                StAdvance: begin
                    // Last window keeps the index so out_addr never passes the final result.
                    if ((row_q == RowLast) && (col_q == ColLast)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                        idx_d   = idx_q + 12'd1;
                        if (col_q < ColLast) begin
                            col_d = col_q + 7'd1;
                        end else begin
                            col_d = '0;
                            row_d = row_q + 7'd1;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= StIdle;
            fcnt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            if (win_we) begin
                win_q[win_sel] <= pix_rdata;
            end
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pix
        assign core_pix[k*DATA_W +: DATA_W] = win_q[k];
    end

    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        core_start = (state_q == StCompute);
        out_valid  = (state_q == StWrite);
        out_data   = res_q;
        out_addr   = idx_q;
    end

endmodule

// File: tb/tb_conv2d_window_sched.sv
// Randomized bench for conv2d_window_sched: pixel memory, summing core model, and a reference
// that computes every window sum straight from the image array.
module tb_conv2d_window_sched;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int NRES = (W - 2) * (H - 2);
`ifdef CONV_SCHED_RELU_EN
    localparam int NEG_EXP = 0;
`else
    localparam int NEG_EXP = 32'h0000_FFF9;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort;
    logic            busy, done, pix_rd_en, core_start, out_valid, out_ready, core_done;
    logic [11:0]     pix_addr, out_addr;
    logic [DW-1:0]   pix_rdata;
    logic [9*DW-1:0] core_pix;
    logic [AW-1:0]   core_result, out_data;

    always #5 clk = ~clk;

    conv2d_window_sched #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .pix_rd_en     (pix_rd_en),
        .pix_addr      (pix_addr),
        .pix_rdata     (pix_rdata),
        .core_start    (core_start),
        .core_pix      (core_pix),
        .core_done     (core_done),
        .core_result   (core_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic signed [DW-1:0] img [W*H];
    int exp_q[$];
    int mon_idx   = 0;
    int done_cnt  = 0;
    int base_done = 0;
    bit ready_rand = 1'b0;
    bit stall_arm  = 1'b0;
    bit core_neg   = 1'b0;
    bit inject_cd  = 1'b0;
    int core_lat   = 0;

    // Pixel memory: read data valid for the whole cycle after the strobe.
    initial begin
        logic        en;
        logic [11:0] a;
        pix_rdata = '0;
        forever begin
            @(negedge clk);
            en = pix_rd_en;
            a  = pix_addr;
            @(posedge clk);
            #1;
            if (en) pix_rdata = (int'(a) < W * H) ? img[int'(a)] : '0;
        end
    end

    // Conv core model: sums the presented window after a short latency.
    initial begin
        int              pend;
        int              s;
        logic [9*DW-1:0] held;
        logic [9*DW-1:0] tmp;
        logic signed [DW-1:0] p;
        logic [AW-1:0]   res;
        pend = 0;
        core_done = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    check("core_pix_hold", 32'(core_pix == held), 32'd1);
                    core_done   = 1'b1;
                    core_result = res;
                end
            end else if (core_start) begin
                held = core_pix;
                s = 0;
                for (int k = 0; k < 9; k++) begin
                    tmp = core_pix >> (k * DW);
                    p   = tmp[DW-1:0];
                    s  += int'(p);
                end
                res  = core_neg ? 16'hFFF9 : s[AW-1:0];
                pend = (core_lat > 0) ? core_lat : int'($urandom_range(1, 4));
            end else if (inject_cd && pix_rd_en) begin
                core_done   = 1'b1;
                core_result = 16'h1234;
                inject_cd   = 1'b0;
            end
        end
    end

    // Consumer: ready pattern plus one long stall on result 5 when armed.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm && out_valid && (out_addr == 12'd5)) begin
                stall_arm = 1'b0;
                out_ready = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_addr", 32'(out_addr), 32'd5);
                    check("stall_data", 32'(out_data), exp_q[0]);
                    check("stall_no_read", 32'(pix_rd_en), 32'd0);
                end
            end else begin
                out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Result monitor against the reference queue.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 32'hDEAD_BEEF;
                check("out_addr", 32'(out_addr), 32'(mon_idx));
                check("out_data", 32'(out_data), e);
                mon_idx++;
            end
        end
    end

    task automatic build_expected();
        int s;
        exp_q.delete();
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) s += int'(img[(r + i) * W + c + j]);
                exp_q.push_back(core_neg ? NEG_EXP : (s & 32'hFFFF));
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * H; i++) img[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic start_run();
        build_expected();
        mon_idx   = 0;
        base_done = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt == base_done && cyc < 4000) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(cyc < 4000), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 32'(mon_idx), 32'(NRES));
        check({tag, "_done"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < W * H; i++) img[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(pix_rd_en), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_core_pix", 32'(core_pix == '0), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All-ones image, always ready.
        for (int i = 0; i < W * H; i++) img[i] = 8'sd1;
        start_run();
        finish_run("ones");

        // Ramp image; window 0 read order and fetch-to-compute timing.
        for (int i = 0; i < W * H; i++) img[i] = DW'(i);
        start_run();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("w0_rd_en", 32'(pix_rd_en), 32'd1);
            check("w0_addr", 32'(pix_addr), 32'((k / 3) * W + (k % 3)));
        end
        @(negedge clk);
        check("fetch9_rd_en", 32'(pix_rd_en), 32'd0);
        check("fetch9_core_start", 32'(core_start), 32'd0);
        @(negedge clk);
        check("compute_core_start", 32'(core_start), 32'd1);
        finish_run("ramp");

        // Random image, random ready, stall on result 5, stray start and core_done.
        fill_random();
        ready_rand = 1'b1;
        stall_arm  = 1'b1;
        start_run();
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        inject_cd = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run("rand");
        check("stall_taken", 32'(stall_arm), 32'd0);
        ready_rand = 1'b0;

        // Abort in the WAIT state of window 10, then restart.
        fill_random();
        core_lat = 3;
        start_run();
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(core_start && out_addr == 12'd10) && cyc < 4000);
        check("abort_reach_w10", 32'(cyc < 4000), 32'd1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_results", 32'(mon_idx), 32'd10);
        repeat (20) @(posedge clk);
        check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        core_lat = 0;
        fill_random();
        start_run();
        finish_run("restart");

        // Negative core result.
        core_neg = 1'b1;
        fill_random();
        start_run();
        finish_run("neg");
        core_neg = 1'b0;

        // Reset in the middle of a run.
        fill_random();
        start_run();
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_rd_en", 32'(pix_rd_en), 32'd0);
        check("midrst_out_addr", 32'(out_addr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
